// File: rtl/cc_branch_unit_if.sv
// cc_branch_unit_if: control/status bundle for cc_branch_unit. The master drives Bus_In,
// LOAD_CC, IR_part, LOAD_BEN, CC_PUSH, CC_POP and ERR_CLR. The slave returns BEN_out,
// NZP_out, Stack_Count, Stack_Full, Stack_Empty and Stack_Err.
interface cc_branch_unit_if #(parameter int WIDTH = 16, parameter int DEPTH = 4);
  logic [WIDTH-1:0]           Bus_In;
  logic                       LOAD_CC;
  logic [2:0]                 IR_part;
  logic                       LOAD_BEN;
  logic                       CC_PUSH;
  logic                       CC_POP;
  logic                       ERR_CLR;
  logic                       BEN_out;
  logic [2:0]                 NZP_out;
  logic [$clog2(DEPTH+1)-1:0] Stack_Count;
  logic                       Stack_Full;
  logic                       Stack_Empty;
  logic                       Stack_Err;
  modport master (output Bus_In, LOAD_CC, IR_part, LOAD_BEN, CC_PUSH, CC_POP, ERR_CLR,
                  input BEN_out, NZP_out, Stack_Count, Stack_Full, Stack_Empty, Stack_Err);
  modport slave  (input Bus_In, LOAD_CC, IR_part, LOAD_BEN, CC_PUSH, CC_POP, ERR_CLR,
                  output BEN_out, NZP_out, Stack_Count, Stack_Full, Stack_Empty, Stack_Err);
endinterface

// File: rtl/cc_branch_unit.sv
// cc_branch_unit: NZP condition-code register, registered BEN and a DEPTH-entry NZP save stack.
// Ports: Clk and Reset (asynchronous, active-high), plus bus (cc_branch_unit_if.slave) carrying the bus value, control strobes and status.
// Optional macro CC_BYPASS_EN: when it is defined, BEN is evaluated against the incoming NZP instead of the registered NZP.
module cc_branch_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic             Clk,
  input logic             Reset,
  cc_branch_unit_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [2:0]    r_nzp;
  logic          r_ben;
  logic          r_err;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_stk [DEPTH];
  logic          w_n, w_z, w_push, w_pop, w_full, w_empty, w_push_ok, w_pop_ok, w_err;
  logic [2:0]    w_cc, w_nzp_nxt, w_ben_src;
  logic [AW-1:0] w_wr, w_rd;
  always_comb begin
    w_n       = bus.Bus_In[WIDTH-1];
    w_z       = bus.Bus_In == '0;
    w_cc      = {w_n, w_z, ~w_n & ~w_z};
    w_push    = bus.CC_PUSH & ~bus.CC_POP;
    w_pop     = bus.CC_POP & ~bus.CC_PUSH;
    w_full    = r_cnt == CW'(DEPTH);
    w_empty   = r_cnt == '0;
    w_push_ok = w_push & ~w_full;
    w_pop_ok  = w_pop & ~w_empty;
    // collision, overflow and underflow all leave the stack untouched and flag an error
    w_err     = (bus.CC_PUSH & bus.CC_POP) | (w_push & w_full) | (w_pop & w_empty);
    w_wr      = AW'(r_cnt);
    w_rd      = AW'(r_cnt - CW'(1));
    w_nzp_nxt = w_pop_ok ? r_stk[w_rd] : bus.LOAD_CC ? w_cc : r_nzp;
`ifdef CC_BYPASS_EN
    w_ben_src = w_nzp_nxt;
`else
    w_ben_src = r_nzp;
`endif
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      r_nzp <= 3'b010;
      r_ben <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_nzp <= w_nzp_nxt;
      r_ben <= bus.LOAD_BEN ? |(bus.IR_part & w_ben_src) : r_ben;
      r_err <= w_err | (r_err & ~bus.ERR_CLR);
      r_cnt <= w_push_ok ? r_cnt + CW'(1) : w_pop_ok ? r_cnt - CW'(1) : r_cnt;
    end
  // storage is unreset; only entries below the count are ever read
  always_ff @(posedge Clk)
    if (w_push_ok) r_stk[w_wr] <= r_nzp;
  assign bus.BEN_out     = r_ben;
  assign bus.NZP_out     = r_nzp;
  assign bus.Stack_Count = r_cnt;
  assign bus.Stack_Full  = w_full;
  assign bus.Stack_Empty = w_empty;
  assign bus.Stack_Err   = r_err;
endmodule

// File: doc/cc_branch_unit.md
Name: cc_branch_unit

Overview:
- Parametrised successor to the LC-3 condition-code/BEN logic.
- Holds the NZP condition-code register, loaded from a WIDTH-bit bus value, and a registered branch-enable (BEN) computed against IR[11:9].
- Adds a DEPTH-entry LIFO of saved condition codes. The control FSM uses it to save and restore NZP across interrupt/trap entry and exit, with full/empty status and a sticky error flag.

Parameters:
- WIDTH, 16: bus data width; sign bit is Bus_In[WIDTH-1]; legal range 2 or more.
- DEPTH, 4: number of entries in the CC save stack; legal range 1 or more.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Bus_In  in  WIDTH  value on the datapath bus; source for new condition codes.
- LOAD_CC  in  1  load NZP from Bus_In this cycle.
- IR_part  in  3  branch condition mask {n,z,p} from IR[11:9].
- LOAD_BEN  in  1  register BEN this cycle.
- CC_PUSH  in  1  push current NZP onto save stack.
- CC_POP  in  1  pop top of save stack into NZP.
- ERR_CLR  in  1  synchronous clear of Stack_Err.
- BEN_out  out  1  registered branch enable.
- NZP_out  out  3  current condition-code register {N,Z,P}.
- Stack_Count  out  $clog2(DEPTH+1)  number of valid stack entries.
- Stack_Full  out  1  Stack_Count == DEPTH (combinational from count).
- Stack_Empty  out  1  Stack_Count == 0 (combinational from count).
- Stack_Err  out  1  sticky overflow/underflow/collision flag.

Behaviour:
- Reset (asynchronous, active-high, immediate on assertion):
  - NZP = 3'b010, BEN_out = 0, Stack_Count = 0, Stack_Err = 0.
  - Stack storage is not reset and is not observable while empty.
- CC generation:
  - N = Bus_In[WIDTH-1].
  - Z = (Bus_In == 0).
  - P = ~N & ~Z.
  - NZP is always exactly one-hot.
- NZP register next-state priority, highest first:
  1. Legal pop (CC_POP & ~CC_PUSH & ~Stack_Empty): NZP <= stack top.
  2. LOAD_CC: NZP <= generated CC.
  3. Otherwise NZP holds.
- BEN:
  - When LOAD_BEN: BEN_out <= |(IR_part & NZP_src); otherwise BEN_out holds.
  - NZP_src is the NZP register value before this edge (see Optional Feature).
  - Latency: 1 cycle from LOAD_BEN to BEN_out.
- Stack operations:
  - Push (CC_PUSH & ~CC_POP):
    - If not full: write the pre-edge NZP value to entry[Stack_Count] and increment the count.
    - If full: stack and count unchanged; Stack_Err <= 1.
  - Pop (CC_POP & ~CC_PUSH):
    - If not empty: decrement the count; NZP <= entry[Stack_Count-1].
    - If empty: NZP follows rule 2 or 3; Stack_Err <= 1.
  - CC_PUSH & CC_POP in the same cycle is illegal: stack, count and NZP-from-pop are untouched; LOAD_CC still applies; Stack_Err <= 1.
  - A push and LOAD_CC in the same cycle push the old NZP; the new CC then lands in the register.
- Stack_Err:
  - Set by any error condition above; cleared by ERR_CLR.
  - If set and clear occur in the same cycle, set wins.
- Count arithmetic never wraps: it saturates at 0 and DEPTH, because illegal ops are blocked.

Optional Feature:
- Macro: CC_BYPASS_EN.
- Defined: when LOAD_BEN and an NZP update (pop or LOAD_CC) occur in the same cycle, BEN is evaluated against the incoming NZP value (forwarded). This allows a compressed microsequence with CC load and BEN in one state.
- Undefined: BEN always uses the pre-edge NZP register value.
- Reset values and stack behaviour are identical either way.

Test Plan:
- Reset mid-operation: Reset asserted asynchronously between edges -> NZP_out=010, BEN_out=0, Stack_Count=0, Stack_Empty=1 immediately, before the next edge.
- CC generation (WIDTH=16):
  - LOAD_CC with Bus_In=16'h8000 -> NZP=100.
  - Bus_In=0 -> NZP=010.
  - Bus_In=16'h0001 -> NZP=001.
  - Then IR_part=011 with LOAD_BEN -> BEN_out=1 one cycle later.
- Same-cycle CC load and BEN:
  - Setup: NZP=100; LOAD_CC with Bus_In=0, LOAD_BEN and IR_part=010 in the same cycle.
  - Without CC_BYPASS_EN -> BEN_out=0.
  - With CC_BYPASS_EN -> BEN_out=1.
- Stack round trip (DEPTH=4):
  - Push NZP=001, 100, 010, 001 -> Stack_Full=1, Stack_Count=4.
  - Fifth push -> Stack_Err=1, count stays 4.
  - Four pops -> NZP sequence 001, 010, 100, 001, then Stack_Empty=1.
- Underflow: pop while empty with LOAD_CC and Bus_In=16'hFFFF -> NZP=100, Stack_Err=1, count=0. Then ERR_CLR -> Stack_Err=0.
- Collision: CC_PUSH and CC_POP together with count=2 -> count stays 2, NZP unchanged, Stack_Err=1.
